// File: rtl/bldc_commutation_controller_if.sv
// Signal bundle between the motor-control host and the BLDC commutation sequencer.
// The host drives hall/enable/direction/duty and reads the gate enables and status.
interface bldc_commutation_controller_if #(
    parameter int PWM_BITS = 8
);
    logic [2:0]          hall;
    logic                enable;
    logic                direction;
    logic [PWM_BITS-1:0] duty;
    logic [2:0]          high_on;
    logic [2:0]          low_on;
    logic                running;
    logic                fault;
    logic [1:0]          fault_code;
    logic [15:0]         position;

    modport master (
        output hall, enable, direction, duty,
        input  high_on, low_on, running, fault, fault_code, position
    );

    modport slave (
        input  hall, enable, direction, duty,
        output high_on, low_on, running, fault, fault_code, position
    );
endinterface

// File: rtl/bldc_commutation_controller.sv
// Six-step BLDC commutation: hall sync/debounce, sequence validation, PWM gate drive
// with dead time between steps, signed position tracking and latched fault reporting.
//
// state   | meaning
// IDLE    | gates off, waiting for enable with a debounced hall code
// RUN     | table entry for hall_stable driven, high side PWM-gated
// DEAD    | all gates off for DEAD_CYCLES clocks after a commutation
// FAULT   | gates off, fault_code held until enable drops
module bldc_commutation_controller #(
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEAD_CYCLES     = 8,
    parameter int STALL_CYCLES    = 100000
) (
    input logic                          clock,
    input logic                          reset_n,
    bldc_commutation_controller_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DEAD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DEAD_W  = $clog2(DEAD_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [DEB_W-1:0]   DEB_LOAD   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEAD_W-1:0]  DEAD_LOAD  = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYCLES - 1);

    state_t              state, state_nx;
    logic [2:0]          sync1, sync2;
    logic [1:0]          sync_vld;
    logic [2:0]          cand;
    logic                cand_vld;
    logic [DEB_W-1:0]    deb_cnt, deb_left;
    logic                deb_hit;
    logic [2:0]          hall_stable;
    logic                hall_ready;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic [DEAD_W-1:0]   dead_cnt, dead_nx;
    logic [STALL_W-1:0]  stall_cnt;
    logic                stall_hit, run_like;
    logic                dir_q, dir_nx;
    logic [15:0]         pos_q, pos_nx;
    logic [1:0]          code_q, code_nx;
    logic [2:0]          idx_old, idx_new, idx_fwd, idx_bwd;
    logic [5:0]          pair;
    logic [2:0]          hi_sel, lo_sel, high_q, low_q;

    // Position of a hall code in the forward sequence; 7 marks 000/111.
    function automatic logic [2:0] seq_idx(input logic [2:0] h);
        case (h)
            3'b101:  seq_idx = 3'd0;
            3'b100:  seq_idx = 3'd1;
            3'b110:  seq_idx = 3'd2;
            3'b010:  seq_idx = 3'd3;
            3'b011:  seq_idx = 3'd4;
            3'b001:  seq_idx = 3'd5;
            default: seq_idx = 3'd7;
        endcase
    endfunction

    // Forward {high phase, low phase} one-hot {A,B,C}.
    function automatic logic [5:0] fwd_pair(input logic [2:0] h);
        case (h)
            3'b101:  fwd_pair = 6'b100_010;
            3'b100:  fwd_pair = 6'b100_001;
            3'b110:  fwd_pair = 6'b010_001;
            3'b010:  fwd_pair = 6'b010_100;
            3'b011:  fwd_pair = 6'b001_100;
            3'b001:  fwd_pair = 6'b001_010;
            default: fwd_pair = 6'b000_000;
        endcase
    endfunction

    assign idx_old = seq_idx(hall_stable);
    assign idx_new = seq_idx(sync2);
    assign idx_fwd = (idx_old == 3'd5) ? 3'd0 : idx_old + 3'd1;
    assign idx_bwd = (idx_old == 3'd0) ? 3'd5 : idx_old - 3'd1;

    always_comb begin
        deb_left = DEB_LOAD;
        if (cand_vld && (sync2 == cand)) deb_left = deb_cnt;
    end

    // sync_vld keeps the reset contents of the synchroniser from being debounced as a code.
    assign deb_hit = sync_vld[1] && (deb_left == '0) && (!hall_ready || (sync2 != hall_stable));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            sync_vld    <= '0;
            cand        <= '0;
            cand_vld    <= 1'b0;
            deb_cnt     <= '0;
            hall_stable <= '0;
            hall_ready  <= 1'b0;
        end else begin
            sync1    <= bus.hall;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1]) begin
                cand     <= sync2;
                cand_vld <= 1'b1;
                deb_cnt  <= (deb_left == '0) ? '0 : deb_left - 1'b1;
                if (deb_hit) begin
                    hall_stable <= sync2;
                    hall_ready  <= 1'b1;
                end
            end
        end
    end

    assign run_like  = (state == S_RUN) || (state == S_DEAD);
    assign stall_hit = run_like && (bus.duty != '0) && (stall_cnt == '0);
    assign pwm_on    = (pwm_cnt < bus.duty);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            dir_q    <= 1'b0;
            pos_q    <= '0;
            code_q   <= '0;
            dead_cnt <= '0;
        end else begin
            state    <= state_nx;
            dir_q    <= dir_nx;
            pos_q    <= pos_nx;
            code_q   <= code_nx;
            dead_cnt <= dead_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir_q;
        pos_nx   = pos_q;
        code_nx  = code_q;
        dead_nx  = dead_cnt;
        case (state)
            S_IDLE: begin
                if (bus.enable && hall_ready) begin
                    if (idx_old == 3'd7) begin
                        state_nx = S_FAULT;
                        code_nx  = 2'b01;
                    end else begin
                        state_nx = S_RUN;
                        dir_nx   = bus.direction;
                    end
                end
            end
            S_RUN, S_DEAD: begin
                if (!bus.enable) begin
                    state_nx = S_IDLE;
                end else if (deb_hit) begin
                    // hall_stable is always a valid code while in RUN/DEAD.
                    if (idx_new == 3'd7) begin
                        state_nx = S_FAULT;
                        code_nx  = 2'b01;
                    end else if (idx_new == idx_fwd) begin
                        state_nx = S_DEAD;
                        pos_nx   = pos_q + 16'd1;
                        dead_nx  = DEAD_LOAD;
                    end else if (idx_new == idx_bwd) begin
                        state_nx = S_DEAD;
                        pos_nx   = pos_q - 16'd1;
                        dead_nx  = DEAD_LOAD;
                    end else begin
                        state_nx = S_FAULT;
                        code_nx  = 2'b10;
                    end
                end else if (stall_hit) begin
                    state_nx = S_FAULT;
                    code_nx  = 2'b11;
                end else if (state == S_DEAD) begin
                    if (dead_cnt == '0) state_nx = S_RUN;
                    else                dead_nx  = dead_cnt - 1'b1;
                end
            end
            S_FAULT: begin
                if (!bus.enable) begin
                    state_nx = S_IDLE;
                    code_nx  = 2'b00;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (!run_like || (bus.duty == '0) || deb_hit) stall_cnt <= STALL_LOAD;
            else if (stall_cnt != '0)                     stall_cnt <= stall_cnt - 1'b1;
        end
    end

    // Reverse direction swaps the high and low phase of each table entry.
    assign pair   = fwd_pair(hall_stable);
    assign hi_sel = dir_q ? pair[2:0] : pair[5:3];
    assign lo_sel = dir_q ? pair[5:3] : pair[2:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            high_q <= '0;
            low_q  <= '0;
        end else if ((state == S_RUN) && bus.enable) begin
            high_q <= pwm_on ? hi_sel : 3'b000;
            low_q  <= lo_sel;
        end else begin
            high_q <= '0;
            low_q  <= '0;
        end
    end

    assign bus.high_on    = high_q;
    assign bus.low_on     = low_q;
    assign bus.running    = run_like;
    assign bus.fault      = (state == S_FAULT);
    assign bus.fault_code = code_q;
    assign bus.position   = pos_q;
endmodule

// File: tb/tb_bldc_commutation_controller.sv
// Directed bench for the BLDC commutation sequencer: PWM duty, six-step sequence,
// reverse drive, debounce, fault codes, stall timing and asynchronous reset.
module tb_bldc_commutation_controller;
    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    logic overlap_seen = 1'b0;

    bldc_commutation_controller_if #(.PWM_BITS(8)) bus ();
    bldc_commutation_controller_if #(.PWM_BITS(8)) bus_s ();

    bldc_commutation_controller dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    bldc_commutation_controller #(.STALL_CYCLES(20)) dut_stall (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_s)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (((bus.high_on & bus.low_on) != 3'b000) || ((bus_s.high_on & bus_s.low_on) != 3'b000))
            overlap_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_running(input int limit);
        int n = 0;
        while (!bus.running && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    logic [2:0] step_hall [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    logic [2:0] step_hi   [6] = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b001, 3'b100};
    logic [2:0] step_lo   [6] = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b010, 3'b010};

    initial begin
        int         hi_n, bad_hi, bad_lo, dead_n, n;
        logic [2:0] hi_or;

        reset_n         = 1'b0;
        bus.hall        = 3'b101;
        bus.enable      = 1'b0;
        bus.direction   = 1'b0;
        bus.duty        = 8'd128;
        bus_s.hall      = 3'b101;
        bus_s.enable    = 1'b0;
        bus_s.direction = 1'b0;
        bus_s.duty      = 8'd10;
        tick(3);
        chk("rst_high_on", bus.high_on, 3'b000);
        chk("rst_low_on", bus.low_on, 3'b000);
        chk("rst_running", bus.running, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        chk("rst_code", bus.fault_code, 2'b00);
        chk("rst_position", bus.position, 16'h0000);

        // Forward start at 101, duty 128
        bus.enable = 1'b1;
        reset_n    = 1'b1;
        wait_running(60);
        chk("start_running", bus.running, 1'b1);
        tick(3);
        hi_n = 0; bad_hi = 0; bad_lo = 0;
        for (int c = 0; c < 256; c++) begin
            tick(1);
            if (bus.high_on == 3'b100) hi_n++;
            else if (bus.high_on != 3'b000) bad_hi++;
            if (bus.low_on != 3'b010) bad_lo++;
        end
        chk("pwm_high_count", hi_n, 128);
        chk("pwm_high_other", bad_hi, 0);
        chk("pwm_low_steady", bad_lo, 0);

        // Full forward revolution
        bus.duty = 8'd255;
        tick(2);
        for (int s = 0; s < 6; s++) begin
            bus.hall = step_hall[s];
            dead_n = 0;
            hi_or  = 3'b000;
            for (int c = 0; c < 50; c++) begin
                tick(1);
                if (bus.low_on == 3'b000) dead_n++;
                if (c >= 40) hi_or = hi_or | bus.high_on;
            end
            chk($sformatf("step%0d_dead", s), dead_n, 8);
            chk($sformatf("step%0d_high", s), hi_or, step_hi[s]);
            chk($sformatf("step%0d_low", s), bus.low_on, step_lo[s]);
        end
        chk("position_fwd", bus.position, 16'd6);

        // Jump 101 -> 110
        bus.hall = 3'b110;
        tick(20);
        chk("jump_fault", bus.fault, 1'b1);
        chk("jump_code", bus.fault_code, 2'b10);
        chk("jump_position", bus.position, 16'd6);
        chk("jump_running", bus.running, 1'b0);
        bus.enable = 1'b0;
        tick(2);
        chk("jump_clear_code", bus.fault_code, 2'b00);
        chk("jump_clear_fault", bus.fault, 1'b0);

        // Reverse drive after a fresh reset
        reset_n = 1'b0;
        tick(2);
        bus.hall      = 3'b101;
        bus.direction = 1'b1;
        bus.enable    = 1'b1;
        reset_n       = 1'b1;
        wait_running(60);
        chk("rev_running", bus.running, 1'b1);
        tick(5);
        hi_or = 3'b000;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            hi_or = hi_or | bus.high_on;
        end
        chk("rev101_high", hi_or, 3'b010);
        chk("rev101_low", bus.low_on, 3'b100);
        bus.hall = 3'b001;
        tick(40);
        chk("rev_position", bus.position, 16'hFFFF);
        hi_or = 3'b000;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            hi_or = hi_or | bus.high_on;
        end
        chk("rev001_high", hi_or, 3'b010);
        chk("rev001_low", bus.low_on, 3'b001);

        // Two-clock glitch is filtered, held invalid code faults
        bus.hall = 3'b000;
        tick(2);
        bus.hall = 3'b001;
        tick(20);
        chk("glitch_fault", bus.fault, 1'b0);
        chk("glitch_running", bus.running, 1'b1);
        chk("glitch_position", bus.position, 16'hFFFF);
        bus.hall = 3'b000;
        tick(20);
        chk("invalid_fault", bus.fault, 1'b1);
        chk("invalid_code", bus.fault_code, 2'b01);
        bus.hall = 3'b100;
        tick(20);
        chk("fault_hold", bus.fault, 1'b1);
        chk("fault_hold_code", bus.fault_code, 2'b01);
        bus.enable = 1'b0;
        tick(2);
        chk("fault_exit", bus.fault, 1'b0);
        chk("fault_exit_code", bus.fault_code, 2'b00);
        chk("fault_exit_running", bus.running, 1'b0);
        chk("fault_exit_position", bus.position, 16'hFFFF);

        // Stall on the STALL_CYCLES=20 instance
        bus_s.enable = 1'b1;
        n = 0;
        while (!bus_s.running && n < 20) begin
            tick(1);
            n++;
        end
        chk("stall_start", bus_s.running, 1'b1);
        n = 0;
        while (!bus_s.fault && n < 100) begin
            tick(1);
            n++;
        end
        chk("stall_clocks", n, 20);
        chk("stall_code", bus_s.fault_code, 2'b11);
        bus_s.enable = 1'b0;
        tick(2);
        bus_s.duty   = 8'd0;
        bus_s.enable = 1'b1;
        tick(100);
        chk("duty0_no_stall", bus_s.fault, 1'b0);
        chk("duty0_running", bus_s.running, 1'b1);
        bus_s.enable = 1'b0;

        // Asynchronous reset in the middle of a high-side pulse
        bus.direction = 1'b0;
        bus.hall      = 3'b101;
        bus.duty      = 8'd128;
        tick(20);
        bus.enable = 1'b1;
        n = 0;
        while (bus.high_on == 3'b000 && n < 600) begin
            tick(1);
            n++;
        end
        chk("pulse_seen", bus.high_on, 3'b100);
        chk("pos_retained", bus.position, 16'hFFFF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_high_off", bus.high_on, 3'b000);
        chk("async_low_off", bus.low_on, 3'b000);
        chk("async_running", bus.running, 1'b0);
        bus.enable = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk("post_rst_position", bus.position, 16'h0000);
        chk("post_rst_high", bus.high_on, 3'b000);

        chk("phase_overlap", overlap_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
